// File: rtl/systolic_rect.sv
// systolic_rect: weight-stationary ROWS x COLS MAC array. Activations flow east,
// partial sums flow south, weights are double-buffered (shadow/active) per PE.
module systolic_rect_pe #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] west_data,
  input  logic                     west_valid,
  input  logic                     west_switch,
  input  logic signed [DATA_W-1:0] north_weight,
  input  logic                     accept,
  input  logic [ACC_W-1:0]         north_psum,
  output logic signed [DATA_W-1:0] east_data,
  output logic                     east_valid,
  output logic                     east_switch,
  output logic signed [DATA_W-1:0] south_weight,
  output logic [ACC_W-1:0]         psum,
  output logic                     psum_valid,
  output logic                     ovf
);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [DATA_W-1:0]   active;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W:0]             sum;
  logic [ACC_W-1:0]           mac;
  logic                       over;
  logic                       fire;

  // One guard bit above the accumulator catches signed overflow of the add.
  always_comb begin
    prod = west_data * active;
    sum  = {north_psum[ACC_W-1], north_psum}
         + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    over = sum[ACC_W] ^ sum[ACC_W-1];
    mac  = sum[ACC_W-1:0];
    if (SATURATE != 0 && over) mac = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    fire = west_valid && en;
    ovf  = fire && over;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      east_data    <= '0;
      east_valid   <= 1'b0;
      east_switch  <= 1'b0;
      south_weight <= '0;
      active       <= '0;
      psum         <= '0;
      psum_valid   <= 1'b0;
    end else begin
      east_data   <= west_data;
      east_valid  <= west_valid;
      east_switch <= west_switch;
      if (accept) south_weight <= north_weight;
      // Reads the pre-shift shadow, so a coincident accept never leaks in.
      if (west_switch) active <= south_weight;
      psum_valid <= fire;
      psum       <= fire ? mac : '0;
    end
  end
endmodule

module systolic_rect #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ROWS-1:0][DATA_W-1:0]  sys_data_in,
  input  logic [ROWS-1:0]              sys_valid_in,
  input  logic [ROWS-1:0]              sys_switch_in,
  input  logic [COLS-1:0][DATA_W-1:0]  sys_weight_in,
  input  logic [COLS-1:0]              sys_accept_w,
  input  logic [COLS-1:0][ACC_W-1:0]   sys_psum_in,
  input  logic [15:0]                  ub_rd_col_size_in,
  input  logic                         ub_rd_col_size_valid_in,
  output logic [COLS-1:0][ACC_W-1:0]   sys_data_out,
  output logic [COLS-1:0]              sys_valid_out,
  output logic [COLS-1:0]              sys_ovf_out
);
  logic [ROWS-1:0][COLS:0][DATA_W-1:0] dw;
  logic [ROWS-1:0][COLS:0]             vw, sw;
  logic [ROWS:0][COLS-1:0][DATA_W-1:0] wn;
  logic [ROWS:0][COLS-1:0][ACC_W-1:0]  pn;
  logic [ROWS-1:0][COLS-1:0]           pv, ovf_pe;
  logic [COLS-1:0]                     col_en, ovf_hit, ovf_q;
  logic [15:0]                         col_size;
  logic                                unused_tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_size <= '0;
      ovf_q    <= '0;
    end else if (ub_rd_col_size_valid_in) begin
      col_size <= (ub_rd_col_size_in > 16'(COLS)) ? 16'(COLS) : ub_rd_col_size_in;
      ovf_q    <= '0;
    end else begin
      ovf_q <= ovf_q | ovf_hit;
    end
  end

  // East edge, south shadow edge and non-bottom psum valids have no consumer.
  always_comb begin
    ovf_hit     = '0;
    unused_tail = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      ovf_hit     = ovf_hit | ovf_pe[r];
      unused_tail = unused_tail ^ (^dw[r][COLS]) ^ vw[r][COLS] ^ sw[r][COLS];
    end
    for (int r = 0; r < ROWS-1; r++) unused_tail = unused_tail ^ (^pv[r]);
    unused_tail = unused_tail ^ (^wn[ROWS]);
  end

  for (genvar c = 0; c < COLS; c++) begin : g_edge
    assign col_en[c]        = col_size > 16'(c);
    assign wn[0][c]         = sys_weight_in[c];
    assign pn[0][c]         = sys_psum_in[c];
    assign sys_data_out[c]  = pn[ROWS][c];
    assign sys_valid_out[c] = pv[ROWS-1][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign dw[r][0] = sys_data_in[r];
    assign vw[r][0] = sys_valid_in[r];
    assign sw[r][0] = sys_switch_in[r];
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_rect_pe #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .SATURATE(SATURATE)
      ) u_pe (
        .clk         (clk),
        .rst         (rst),
        .en          (col_en[c]),
        .west_data   (dw[r][c]),
        .west_valid  (vw[r][c]),
        .west_switch (sw[r][c]),
        .north_weight(wn[r][c]),
        .accept      (sys_accept_w[c]),
        .north_psum  (pn[r][c]),
        .east_data   (dw[r][c+1]),
        .east_valid  (vw[r][c+1]),
        .east_switch (sw[r][c+1]),
        .south_weight(wn[r+1][c]),
        .psum        (pn[r+1][c]),
        .psum_valid  (pv[r][c]),
        .ovf         (ovf_pe[r][c])
      );
    end
  end

  assign sys_ovf_out = ovf_q;
endmodule

// File: doc/systolic_rect.md
SYSTOLIC_RECT -- requirements
Module: systolic_rect

Interface
REQ-001 SHALL have parameter ROWS, 4, PE rows (reduction depth K), >=1.
REQ-002 SHALL have parameter COLS, 4, PE columns (output channels), >=1.
REQ-003 SHALL have parameter DATA_W, 8, signed data/weight width.
REQ-004 SHALL have parameter ACC_W, 32, signed accumulator width, >= 2*DATA_W.
REQ-005 SHALL have parameter SATURATE, 0, 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-006 SHALL have one clock and an asynchronous active-high reset: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-007 SHALL have sys_data_in  in  [ROWS] x DATA_W signed  west activations.
REQ-008 SHALL have sys_valid_in  in  [ROWS] x 1  west activation valid.
REQ-009 SHALL have sys_switch_in  in  [ROWS] x 1  per-row weight-switch pulse, entering column 0.
REQ-010 SHALL have sys_weight_in  in  [COLS] x DATA_W signed  north weights.
REQ-011 SHALL have sys_accept_w  in  [COLS] x 1  per-column weight shift enable.
REQ-012 SHALL have sys_psum_in  in  [COLS] x ACC_W signed  north partial-sum seed (K-tiling).
REQ-013 SHALL have ub_rd_col_size_in  in  16  active column count; ub_rd_col_size_valid_in  in  1  load strobe.
REQ-014 SHALL have sys_data_out  out  [COLS] x ACC_W signed  south results; sys_valid_out  out  [COLS] x 1  result valid.
REQ-015 SHALL have sys_ovf_out  out  [COLS] x 1  sticky per-column overflow flag.

Function
REQ-016 Each PE(r,c) SHALL hold a shadow weight and an active weight; accept_w[c] high: shadow(0,c)<=weight_in[c], shadow(r,c)<=shadow(r-1,c) (first word loaded ends in row ROWS-1 after ROWS shifts).
REQ-017 Switch SHALL propagate east one column per cycle via a per-PE register; PE(r,c) copies shadow->active on the edge its switch input is high (column c switches c cycles after assertion).
REQ-018 Accept and switch coincident in a PE: active SHALL take the pre-shift shadow value.
REQ-019 MAC registered on an edge SHALL use the active weight held before that edge (switch never affects same-cycle MAC).
REQ-020 Data and valid SHALL move east one PE per cycle, registered; column 0 uses sys_data_in/sys_valid_in directly.
REQ-021 PE psum register SHALL load psum_north + data*active when west valid and column enabled, else 0 with psum valid 0; psum_north = sys_psum_in[c] for row 0, PE(r-1,c) psum register otherwise.
REQ-022 Product SHALL be full 2*DATA_W signed, sign-extended to ACC_W before add.
REQ-023 Overflow on a valid MAC SHALL clamp to +/-(2^(ACC_W-1)) bounds if SATURATE=1, wrap if 0; either way SHALL set sys_ovf_out[c].
REQ-024 sys_data_out[c]/sys_valid_out[c] SHALL be the psum register/valid of PE(ROWS-1,c).
REQ-025 Latency: with A[i][k] presented on row k at edge E0+i+k, D[i][c] SHALL appear on sys_data_out[c] immediately after edge E0+i+c+ROWS-1.
REQ-026 ub_rd_col_size_valid_in SHALL latch col_size = min(ub_rd_col_size_in, COLS) and clear all sys_ovf_out; column c enabled iff c < col_size.
REQ-027 Disabled columns SHALL output data 0, valid 0, never set overflow; they SHALL still forward data east and accept weights/switch.
REQ-028 col_size = 0 SHALL disable all columns; values > COLS SHALL saturate to COLS.

Reset
REQ-029 rst high SHALL immediately clear all weights, psums, valids, data, switch registers, col_size and sys_ovf_out to 0; all outputs 0 while asserted, including mid-stream.
REQ-030 After rst deassert, first valid result SHALL require a new col_size load and weight load/switch.

Verification
REQ-031 ROWS=2,COLS=2, col_size 2, weights [[2,3],[4,5]], A=[[10,1],[20,2]] skewed, psum_in 0 -> out0 24 then 48, out1 35 then 70 at REQ-025 edges, valid high only those cycles.
REQ-032 Same, sys_psum_in=[100,-100] -> out0 124,148; out1 -65,-30.
REQ-033 COLS=4, col_size 2 -> columns 2,3 valid 0/data 0 throughout; col_size 9 -> all 4 columns active.
REQ-034 ACC_W=16, weights 127, data 127, psum_in 32767: SATURATE=1 -> 32767 and ovf=1; SATURATE=0 -> wrapped value, ovf=1; col_size reload clears ovf.
REQ-035 Load second weight set during streaming, switch between A rows -> row before switch uses old weights, row after uses new, per column skew.
REQ-036 rst asserted mid-stream -> all outputs 0 same cycle; after reload, REQ-031 results reproduce exactly.
